aes_iter_cipher: RTL and testbench

//  Iterative AES core, one round per clock; encrypts or decrypts per block (mode latched at accept).

---
 rtl/aes_iter_cipher.sv | 190 +++++++++++++++++++
 tb/tb_aes_iter_cipher.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_iter_cipher.sv
// rtl/aes_iter_cipher.sv - iterative AES-128/192/256 encrypt/decrypt core, one round per clock
module aes_iter_cipher #(
    parameter int KEY_BITS    = 128,
    parameter bit SUPPORT_DEC = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [127:0] data_in,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);
    localparam int NR = (KEY_BITS == 256) ? 14 : (KEY_BITS == 192) ? 12 : 10;
    localparam logic [3:0] NR4 = NR[3:0];

    if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
        $error("aes_iter_cipher: KEY_BITS must be 128, 192 or 256");
    end

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int b = 0; b < 4; b++) begin
            if (k[b]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
    state_t       state, state_nx;
    logic [127:0] st;
    logic [3:0]   rnd;
    logic         mode_q;
    logic         last;
    logic [7:0]   s_in [16];
    logic [7:0]   k_b  [16];
    logic [7:0]   e_sr [16];
    logic [127:0] enc_res, dec_res, round_res;

    assign last = (rnd == NR4);

    // SubBytes and ShiftRows commute, so the lookup is done on the shifted source byte.
    always_comb begin
        enc_res = '0;
        for (int i = 0; i < 16; i++) begin
            s_in[i] = st[127-8*i -: 8];
            k_b[i]  = rk_in[127-8*i -: 8];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                e_sr[4*c+r] = SBOX[s_in[4*((c+r)%4)+r]];
        for (int c = 0; c < 4; c++) begin
            enc_res[127-32*c -: 8]  = k_b[4*c]   ^ (last ? e_sr[4*c] :
                xt(e_sr[4*c]) ^ xt(e_sr[4*c+1]) ^ e_sr[4*c+1] ^ e_sr[4*c+2] ^ e_sr[4*c+3]);
            enc_res[119-32*c -: 8]  = k_b[4*c+1] ^ (last ? e_sr[4*c+1] :
                e_sr[4*c] ^ xt(e_sr[4*c+1]) ^ xt(e_sr[4*c+2]) ^ e_sr[4*c+2] ^ e_sr[4*c+3]);
            enc_res[111-32*c -: 8]  = k_b[4*c+2] ^ (last ? e_sr[4*c+2] :
                e_sr[4*c] ^ e_sr[4*c+1] ^ xt(e_sr[4*c+2]) ^ xt(e_sr[4*c+3]) ^ e_sr[4*c+3]);
            enc_res[103-32*c -: 8]  = k_b[4*c+3] ^ (last ? e_sr[4*c+3] :
                xt(e_sr[4*c]) ^ e_sr[4*c] ^ e_sr[4*c+1] ^ e_sr[4*c+2] ^ xt(e_sr[4*c+3]));
        end
    end

    if (SUPPORT_DEC) begin : g_dec
        localparam logic [7:0] INV_SBOX [256] = '{
            8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
            8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
            8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
            8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
            8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
            8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
            8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
            8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
            8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
            8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
            8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
            8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
            8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
            8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
            8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
            8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
        };
        logic [7:0] ark [16];

        always_comb begin
            dec_res = '0;
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    ark[4*c+r] = INV_SBOX[s_in[4*((c-r+4)%4)+r]] ^ k_b[4*c+r];
            for (int c = 0; c < 4; c++) begin
                dec_res[127-32*c -: 8] = last ? ark[4*c] : gmul(ark[4*c], 4'he) ^
                    gmul(ark[4*c+1], 4'hb) ^ gmul(ark[4*c+2], 4'hd) ^ gmul(ark[4*c+3], 4'h9);
                dec_res[119-32*c -: 8] = last ? ark[4*c+1] : gmul(ark[4*c], 4'h9) ^
                    gmul(ark[4*c+1], 4'he) ^ gmul(ark[4*c+2], 4'hb) ^ gmul(ark[4*c+3], 4'hd);
                dec_res[111-32*c -: 8] = last ? ark[4*c+2] : gmul(ark[4*c], 4'hd) ^
                    gmul(ark[4*c+1], 4'h9) ^ gmul(ark[4*c+2], 4'he) ^ gmul(ark[4*c+3], 4'hb);
                dec_res[103-32*c -: 8] = last ? ark[4*c+3] : gmul(ark[4*c], 4'hb) ^
                    gmul(ark[4*c+1], 4'hd) ^ gmul(ark[4*c+2], 4'h9) ^ gmul(ark[4*c+3], 4'he);
            end
        end
    end else begin : g_no_dec
        assign dec_res = '0;
    end

    assign round_res = (SUPPORT_DEC && mode_q) ? dec_res : enc_res;
    assign busy      = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st       <= '0;
            rnd      <= '0;
            mode_q   <= 1'b0;
            data_out <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    st     <= data_in ^ rk_in;
                    mode_q <= SUPPORT_DEC ? mode : 1'b0;
                    rnd    <= 4'd1;
                end
                ROUND: if (last) data_out <= round_res;
                       else begin
                           st  <= round_res;
                           rnd <= rnd + 4'd1;
                       end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rk_idx    = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                rk_idx   = (SUPPORT_DEC && mode) ? NR4 : 4'd0;
                if (in_valid) state_nx = ROUND;
            end
            ROUND: begin
                rk_idx = mode_q ? (NR4 - rnd) : rnd;
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_aes_iter_cipher.sv
// tb/tb_aes_iter_cipher.sv - directed FIPS-197 vector bench for aes_iter_cipher at 128/192/256-bit keys
module tb_aes_iter_cipher;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    localparam logic [7:0] SB [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid [3];
    logic         in_ready [3];
    logic         mode [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic         busy [3];
    logic [127:0] data_in [3];
    logic [127:0] rk_in [3];
    logic [127:0] data_out [3];
    logic [3:0]   rk_idx [3];
    logic [127:0] rks [3][16];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           idx_log [16];
    int           idx_n;
    logic [127:0] res;
    int           lat;
    int           cyc;

    always #5 clock = ~clock;

    assign rk_in[0] = rks[0][rk_idx[0]];
    assign rk_in[1] = rks[1][rk_idx[1]];
    assign rk_in[2] = rks[2][rk_idx[2]];

    aes_iter_cipher #(.KEY_BITS(128)) u_aes128 (
        .clock(clock), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .mode(mode[0]), .data_in(data_in[0]), .rk_idx(rk_idx[0]), .rk_in(rk_in[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .data_out(data_out[0]), .busy(busy[0]));
    aes_iter_cipher #(.KEY_BITS(192)) u_aes192 (
        .clock(clock), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .mode(mode[1]), .data_in(data_in[1]), .rk_idx(rk_idx[1]), .rk_in(rk_in[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .data_out(data_out[1]), .busy(busy[1]));
    aes_iter_cipher #(.KEY_BITS(256)) u_aes256 (
        .clock(clock), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .mode(mode[2]), .data_in(data_in[2]), .rk_idx(rk_idx[2]), .rk_in(rk_in[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .data_out(data_out[2]), .busy(busy[2]));

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SB[w[31:24]], SB[w[23:16]], SB[w[15:8]], SB[w[7:0]]};
    endfunction

    // Standard key expansion; key is left-aligned in 256 bits, nk = 4/6/8 words.
    task automatic expand(input int k, input int nk, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rks[k][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one block, logs rk_idx from the accept cycle to the last round, then drains it.
    task automatic run(input int k, input logic m, input logic [127:0] din,
                       output logic [127:0] r, output int l);
        mode[k]     = m;
        data_in[k]  = din;
        in_valid[k] = 1'b1;
        idx_n       = 0;
        idx_log[0]  = int'(rk_idx[k]);
        idx_n       = 1;
        tick;
        in_valid[k] = 1'b0;
        mode[k]     = ~m;
        data_in[k]  = ~din;
        l = 0;
        while (!out_valid[k] && l < 40) begin
            if (idx_n < 16) begin
                idx_log[idx_n] = int'(rk_idx[k]);
                idx_n++;
            end
            tick;
            l++;
        end
        r = data_out[k];
        out_ready[k] = 1'b1;
        tick;
        out_ready[k] = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            mode[k]      = 1'b0;
            out_ready[k] = 1'b0;
            data_in[k]   = '0;
        end
        expand(0, 4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        expand(1, 6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
        expand(2, 8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        repeat (3) tick;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_in_ready%0d", k), 128'(in_ready[k]), 128'd1);
            chk($sformatf("reset_out_valid%0d", k), 128'(out_valid[k]), 128'd0);
            chk($sformatf("reset_busy%0d", k), 128'(busy[k]), 128'd0);
            chk($sformatf("reset_data_out%0d", k), data_out[k], 128'd0);
        end

        run(0, 1'b0, PT, res, lat);
        chk("enc128_result", res, CT128);
        chk("enc128_latency", 128'(lat), 128'd10);

        run(0, 1'b1, CT128, res, lat);
        chk("dec128_result", res, PT);
        chk("dec128_rk_idx_count", 128'(idx_n), 128'd11);
        for (int i = 0; i < 11; i++)
            chk($sformatf("dec128_rk_idx%0d", i), 128'(idx_log[i]), 128'(10 - i));

        run(1, 1'b0, PT, res, lat);
        chk("enc192_result", res, CT192);
        chk("enc192_latency", 128'(lat), 128'd12);
        run(1, 1'b1, CT192, res, lat);
        chk("dec192_result", res, PT);

        run(2, 1'b0, PT, res, lat);
        chk("enc256_result", res, CT256);
        chk("enc256_latency", 128'(lat), 128'd14);
        run(2, 1'b1, CT256, res, lat);
        chk("dec256_result", res, PT);

        // Backpressure: result held while a competing block waits at the input.
        mode[0]     = 1'b0;
        data_in[0]  = PT;
        in_valid[0] = 1'b1;
        tick;
        in_valid[0] = 1'b0;
        cyc = 0;
        while (!out_valid[0] && cyc < 40) begin
            tick;
            cyc++;
        end
        chk("bp_out_valid", 128'(out_valid[0]), 128'd1);
        mode[0]     = 1'b1;
        data_in[0]  = CT128;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_data_out%0d", i), data_out[0], CT128);
            chk($sformatf("bp_in_ready%0d", i), 128'(in_ready[0]), 128'd0);
            chk($sformatf("bp_hold_valid%0d", i), 128'(out_valid[0]), 128'd1);
            tick;
        end
        out_ready[0] = 1'b1;
        tick;
        out_ready[0] = 1'b0;
        chk("bp_release_in_ready", 128'(in_ready[0]), 128'd1);
        chk("bp_release_busy", 128'(busy[0]), 128'd0);
        tick;
        in_valid[0] = 1'b0;
        chk("bp_second_accepted", 128'(busy[0]), 128'd1);
        cyc = 0;
        while (!out_valid[0] && cyc < 40) begin
            tick;
            cyc++;
        end
        chk("bp_second_result", data_out[0], PT);
        out_ready[0] = 1'b1;
        tick;
        out_ready[0] = 1'b0;

        // Reset while the core is at round 5.
        mode[0]     = 1'b0;
        data_in[0]  = PT;
        in_valid[0] = 1'b1;
        tick;
        in_valid[0] = 1'b0;
        repeat (4) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("rst_mid_in_ready", 128'(in_ready[0]), 128'd1);
        chk("rst_mid_out_valid", 128'(out_valid[0]), 128'd0);
        chk("rst_mid_data_out", data_out[0], 128'd0);
        chk("rst_mid_busy", 128'(busy[0]), 128'd0);
        run(0, 1'b0, PT, res, lat);
        chk("rst_after_result", res, CT128);
        chk("rst_after_latency", 128'(lat), 128'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
